multi_edge_detector: RTL and testbench
======================================

// Module: multi_edge_detector
// PURPOSE
//  Parametrised successor of the single-channel dual edge detector. Watches CHANNELS async inputs.
//  Each channel is synchronised, deglitched by a stability counter and checked against a per-channel
//  mode: off / rise / fall / both. Emits 1-cycle edge pulses, sticky W1C flags and a combined irq.
//  Sits between board-level pins and the control/interrupt logic.
// PARAMETERS
//  CHANNELS       4   number of independent input channels (>=1)
//  SYNC_STAGES    2   synchroniser flops per channel (>=2)
//  FILTER_CYCLES  3   consecutive cycles a new level must persist before it is accepted (>=1)
// PORTS
//  clk        in   1            system clock, all logic on rising edge
//  reset      in   1            synchronous, active-high reset
//  in         in   CHANNELS     raw asynchronous inputs
//  mode       in   2*CHANNELS   per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//  flag_clr   in   CHANNELS     per-channel clear strobe for edge_flag
//  irq_en     in   CHANNELS     per-channel interrupt enable
//  level      out  CHANNELS     filtered (debounced) level
//  edge_pulse out  CHANNELS     1-cycle pulse per accepted edge matching mode
//  edge_flag  out  CHANNELS     sticky edge status
//  irq        out  1            registered OR of (edge_flag & irq_en)
// BEHAVIOUR
//  - Reset: all sync flops, level, edge_pulse, edge_flag, irq, counters = 0; every FSM to STABLE_LOW.
//  - Per-channel FSM, 4 states: STABLE_LOW, CONFIRM_HIGH, STABLE_HIGH, CONFIRM_LOW.
//    - STABLE_x: when the sync output differs from level, go to CONFIRM_y with cnt = 1.
//      When FILTER_CYCLES == 1, accept the new level immediately instead.
//    - CONFIRM_y: sync output back at the old level -> return to STABLE_x, cnt = 0 (glitch rejected).
//      Still different and cnt == FILTER_CYCLES-1 -> accept: go to STABLE_y, level flips, cnt = 0.
//      Otherwise cnt++.
//  - cnt width is $clog2(FILTER_CYCLES+1). cnt never wraps; it only saturates at accept.
//  - Accepted low->high is a rise; accepted high->low is a fall.
//  - edge_pulse[i] is registered on the same edge level flips. It is high exactly one cycle, and
//    only if mode[i] enables that direction. Mode 00 never pulses, but level still tracks the input.
//  - Latency: an input change stable from sampling edge E1 gives level flip and edge_pulse high after
//    rising edge E(SYNC_STAGES+FILTER_CYCLES); irq follows one edge later.
//  - A mode change takes effect for the next accepted edge. The filter FSM is unaffected.
//  - edge_flag[i] sets on the same edge as edge_pulse[i] and holds until flag_clr[i].
//    Set and clear in the same cycle: set wins, flag stays 1.
//  - irq is registered each cycle from the current edge_flag & irq_en. Deasserting irq_en drops irq
//    one cycle later; the flag is kept.
//  - Reset mid-operation: flushes everything; pending CONFIRM progress is discarded.
//    An input held high across reset is then reported as a rise after the normal latency.
//  - Simultaneous edges on several channels are fully independent; no arbitration or loss.
// STRUCTURE
//  - Package med_pkg: mode encodings (MODE_OFF/RISE/FALL/BOTH), FSM state typedef / localparams.
//  - Sub-module edge_detector_channel (one channel: synchroniser, filter FSM, cnt, pulse, flag).
//    The top generate-loops CHANNELS instances and builds irq.
// TESTING
//  1. Default params, mode ch0=01. Drive in[0] 0->1 held.
//     -> edge_pulse[0] one cycle high at edge 5 after sampling; level[0]=1; edge_flag[0]=1;
//        irq=1 one edge later if irq_en[0].
//  2. Glitch: in[1] high for 2 cycles then low, FILTER_CYCLES=3, mode=11.
//     -> no pulse, level[1] stays 0, flag stays 0.
//  3. Mode 10 on ch2, full pulse on in[2] (high 10 cycles, low).
//     -> no pulse on the rise; one pulse on the fall; level follows both.
//  4. Flag already set, flag_clr[0] asserted on the same cycle as a new ch0 edge.
//     -> edge_flag[0] remains 1; a later lone flag_clr[0] clears it; irq drops one cycle after.
//  5. All 4 channels toggle on the same cycle, mode 11.
//     -> all 4 edge_pulse bits high on the same cycle; irq=1 with irq_en=4'hF.
//  6. reset asserted mid-CONFIRM_HIGH with in held 1.
//     -> all outputs 0 during reset; after release a rise pulse at the nominal latency.

Source files
------------

// File: rtl/med_pkg.sv
// Shared encodings for the multi-channel edge detector: per-channel mode codes,
// filter FSM states and small decode helpers.
package med_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_STABLE_LOW   = 2'd0,
    ST_CONFIRM_HIGH = 2'd1,
    ST_STABLE_HIGH  = 2'd2,
    ST_CONFIRM_LOW  = 2'd3
  } filt_state_t;

  function automatic logic mode_rise(input logic [1:0] m);
    return (m != MODE_OFF) && (m != MODE_FALL);
  endfunction

  function automatic logic mode_fall(input logic [1:0] m);
    return (m == MODE_FALL) || (m == MODE_BOTH);
  endfunction

  // The accepted level is high while stable high or while a drop is still unconfirmed.
  function automatic logic state_is_high(input filt_state_t s);
    return (s == ST_STABLE_HIGH) || (s == ST_CONFIRM_LOW);
  endfunction

endpackage

// File: rtl/edge_detector_channel.sv
// One input channel: synchroniser, stability-counter deglitch FSM, mode-qualified
// edge pulse and sticky write-1-to-clear flag.
module edge_detector_channel
  import med_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_in,
  input  logic [1:0] i_mode,
  input  logic       i_flag_clr,
  output logic       o_level,
  output logic       o_pulse,
  output logic       o_flag
);

  localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  filt_state_t            r_state;
  filt_state_t            w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_sync;
  logic                   w_level;
  logic                   w_level_nxt;
  logic                   w_set;
  logic                   r_pulse;
  logic                   r_flag;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= '0;
      r_state <= ST_STABLE_LOW;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_STABLE_LOW: begin
        if (w_sync) begin
          if (FILTER_CYCLES == 1) begin
            w_state_nxt = ST_STABLE_HIGH;
          end else begin
            w_state_nxt = ST_CONFIRM_HIGH;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_CONFIRM_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = ST_STABLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_STABLE_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_STABLE_HIGH: begin
        if (!w_sync) begin
          if (FILTER_CYCLES == 1) begin
            w_state_nxt = ST_STABLE_LOW;
          end else begin
            w_state_nxt = ST_CONFIRM_LOW;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_CONFIRM_LOW: begin
        if (w_sync) begin
          w_state_nxt = ST_STABLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_STABLE_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_STABLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // An accepted edge is exactly a change of the level implied by the state.
  always_comb begin
    w_level     = state_is_high(r_state);
    w_level_nxt = state_is_high(w_state_nxt);
    w_set       = (!w_level &&  w_level_nxt && mode_rise(i_mode)) ||
                  ( w_level && !w_level_nxt && mode_fall(i_mode));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pulse <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_pulse <= w_set;
      r_flag  <= w_set | (r_flag & ~i_flag_clr);
    end
  end

  assign o_level = w_level;
  assign o_pulse = r_pulse;
  assign o_flag  = r_flag;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector: one filter channel per input plus a
// registered interrupt combining enabled sticky flags.
module multi_edge_detector #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   flag_clr,
  input  logic [CHANNELS-1:0]   irq_en,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   edge_pulse,
  output logic [CHANNELS-1:0]   edge_flag,
  output logic                  irq
);

  logic r_irq;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_detector_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .i_in       (in[g]),
      .i_mode     (mode[2*g+1:2*g]),
      .i_flag_clr (flag_clr[g]),
      .o_level    (level[g]),
      .o_pulse    (edge_pulse[g]),
      .o_flag     (edge_flag[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(edge_flag & irq_en);
    end
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector with default parameters (4 ch, 2 sync, filter 3).
module tb_multi_edge_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in;
  logic [7:0] mode;
  logic [3:0] flag_clr;
  logic [3:0] irq_en;
  logic [3:0] level;
  logic [3:0] edge_pulse;
  logic [3:0] edge_flag;
  logic       irq;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [3:0] seen;

  multi_edge_detector #(
    .CHANNELS      (4),
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .mode       (mode),
    .flag_clr   (flag_clr),
    .irq_en     (irq_en),
    .level      (level),
    .edge_pulse (edge_pulse),
    .edge_flag  (edge_flag),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in       = 4'h0;
    mode     = 8'b11_10_11_01;
    flag_clr = 4'h0;
    irq_en   = 4'h1;
    tick(3);
    check("rst_level", 32'(level), 32'h0);
    check("rst_pulse", 32'(edge_pulse), 32'h0);
    check("rst_flag",  32'(edge_flag), 32'h0);
    check("rst_irq",   32'(irq), 32'h0);
    reset = 1'b0;
    tick(3);

    // 1: ch0 rise, mode 01
    in[0] = 1'b1;
    tick(4);
    check("t1_pulse_e4", 32'(edge_pulse), 32'h0);
    check("t1_level_e4", 32'(level), 32'h0);
    tick(1);
    check("t1_pulse_e5", 32'(edge_pulse), 32'h1);
    check("t1_level_e5", 32'(level), 32'h1);
    check("t1_flag_e5",  32'(edge_flag), 32'h1);
    check("t1_irq_e5",   32'(irq), 32'h0);
    tick(1);
    check("t1_pulse_e6", 32'(edge_pulse), 32'h0);
    check("t1_irq_e6",   32'(irq), 32'h1);

    // 2: ch1 glitch of two cycles
    in[1] = 1'b1;
    seen = 4'h0;
    tick(1); seen |= edge_pulse;
    tick(1); seen |= edge_pulse;
    in[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      seen |= edge_pulse;
    end
    check("t2_no_pulse", 32'(seen[1]), 32'h0);
    check("t2_level",    32'(level[1]), 32'h0);
    check("t2_flag",     32'(edge_flag[1]), 32'h0);

    // 3: ch2 fall-only mode
    in[2] = 1'b1;
    seen = 4'h0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      seen |= edge_pulse;
    end
    check("t3_rise_no_pulse", 32'(seen[2]), 32'h0);
    check("t3_level_hi",      32'(level[2]), 32'h1);
    check("t3_flag_after_rise", 32'(edge_flag[2]), 32'h0);
    in[2] = 1'b0;
    tick(4);
    check("t3_pulse_e4", 32'(edge_pulse[2]), 32'h0);
    check("t3_level_e4", 32'(level[2]), 32'h1);
    tick(1);
    check("t3_fall_pulse", 32'(edge_pulse[2]), 32'h1);
    check("t3_level_lo",   32'(level[2]), 32'h0);
    check("t3_flag",       32'(edge_flag[2]), 32'h1);
    tick(1);
    check("t3_pulse_gone", 32'(edge_pulse[2]), 32'h0);

    // 4: set beats clear on ch0
    in[0] = 1'b0;
    seen = 4'h0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      seen |= edge_pulse;
    end
    check("t4_fall_no_pulse", 32'(seen[0]), 32'h0);
    check("t4_flag_held",     32'(edge_flag[0]), 32'h1);
    in[0] = 1'b1;
    tick(4);
    flag_clr[0] = 1'b1;
    tick(1);
    flag_clr[0] = 1'b0;
    check("t4_pulse",        32'(edge_pulse[0]), 32'h1);
    check("t4_set_wins",     32'(edge_flag[0]), 32'h1);
    tick(1);
    check("t4_irq_hi",       32'(irq), 32'h1);
    flag_clr[0] = 1'b1;
    tick(1);
    flag_clr[0] = 1'b0;
    check("t4_flag_cleared", 32'(edge_flag[0]), 32'h0);
    check("t4_irq_lag",      32'(irq), 32'h1);
    tick(1);
    check("t4_irq_dropped",  32'(irq), 32'h0);

    // 5: all channels toggle together, mode both
    mode     = 8'hFF;
    flag_clr = 4'hF;
    tick(1);
    flag_clr = 4'h0;
    irq_en   = 4'hF;
    check("t5_flags_clear", 32'(edge_flag), 32'h0);
    in = 4'b1110;
    tick(4);
    check("t5_pulse_e4", 32'(edge_pulse), 32'h0);
    tick(1);
    check("t5_pulse_all", 32'(edge_pulse), 32'hF);
    check("t5_level",     32'(level), 32'hE);
    check("t5_flag_all",  32'(edge_flag), 32'hF);
    tick(1);
    check("t5_irq",       32'(irq), 32'h1);
    irq_en = 4'h0;
    tick(1);
    check("t5_irq_en_off", 32'(irq), 32'h0);
    check("t5_flag_kept",  32'(edge_flag), 32'hF);

    // 6: reset in the middle of CONFIRM_HIGH
    in = 4'h0;
    tick(8);
    check("t6_level_low", 32'(level), 32'h0);
    in[0] = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("t6_rst_level", 32'(level), 32'h0);
    check("t6_rst_pulse", 32'(edge_pulse), 32'h0);
    check("t6_rst_flag",  32'(edge_flag), 32'h0);
    check("t6_rst_irq",   32'(irq), 32'h0);
    tick(1);
    reset  = 1'b0;
    irq_en = 4'h1;
    tick(4);
    check("t6_pulse_e4", 32'(edge_pulse), 32'h0);
    check("t6_level_e4", 32'(level), 32'h0);
    tick(1);
    check("t6_pulse_e5", 32'(edge_pulse), 32'h1);
    check("t6_level_e5", 32'(level), 32'h1);
    tick(1);
    check("t6_irq", 32'(irq), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
